// File: rtl/ascon_aead128_axil_regs.sv
// AXI4-Lite register bank for the Ascon-AEAD128 core: decodes host writes into
// key/nonce/AD/data transfers and captures core outputs and status for readback.
module ascon_aead128_axil_regs #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter logic [1:0]  RESP_SLVERR = 2'b10
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]            awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]            arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [127:0]          key,
  output logic [127:0]          nonce,
  output logic                  start,
  output logic                  op_mode,
  output logic [127:0]          ad_data,
  output logic                  ad_valid,
  input  logic                  ad_ready,
  output logic [127:0]          db_data,
  output logic                  db_valid,
  input  logic                  db_ready,
  input  logic                  core_ready,
  input  logic [127:0]          dout,
  input  logic                  dout_valid,
  input  logic [127:0]          tag,
  input  logic                  tag_valid
);

  typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_RESP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                  commit, rd_load;
  logic [ADDR_WIDTH-1:0] aw_q, w_addr;
  logic [31:0]           wd_q, w_data;
  logic [3:0]            ws_q, w_strb;
  logic [31:0]           w_idx, r_idx;
  logic [6:0]            w_sel, r_sel;
  logic [31:0]           ctrl_q, ctrl_new, rd_word;
  logic                  rd_ok;
  logic [127:0]          key_q, nonce_q, ad_q, din_q, dout_q, tag_q;
  logic                  end_aead, dout_ready, ad_valid_q, db_valid_q;
  logic                  unused_bits;

  function automatic logic [31:0] merge_strb(input logic [31:0] old,
                                             input logic [31:0] d,
                                             input logic [3:0]  s);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic idx_mapped(input logic [31:0] i);
    return (i <= 32'd1) || (i >= 32'd4 && i <= 32'd27);
  endfunction

  assign unused_bits = ^{awprot, arprot, w_addr[1:0], araddr[1:0]};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // Commit fires on the first cycle both halves are present, whether held or live.
  always_comb begin
    wr_next = wr_state;
    commit  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (awvalid && wvalid) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end else if (awvalid) begin
          wr_next = WR_AW;
        end else if (wvalid) begin
          wr_next = WR_W;
        end
      end
      WR_AW:   if (wvalid)  begin commit = 1'b1; wr_next = WR_RESP; end
      WR_W:    if (awvalid) begin commit = 1'b1; wr_next = WR_RESP; end
      WR_RESP: if (bready)  wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    rd_load = 1'b0;
    case (rd_state)
      RD_IDLE: if (arvalid) begin rd_load = 1'b1; rd_next = RD_DATA; end
      RD_DATA: if (rready)  rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  assign awready = (wr_state == WR_IDLE) || (wr_state == WR_W);
  assign wready  = (wr_state == WR_IDLE) || (wr_state == WR_AW);
  assign bvalid  = (wr_state == WR_RESP);
  assign arready = (rd_state == RD_IDLE);
  assign rvalid  = (rd_state == RD_DATA);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_q <= '0;
      wd_q <= '0;
      ws_q <= '0;
    end else begin
      if (awvalid && awready) aw_q <= awaddr;
      if (wvalid && wready) begin
        wd_q <= wdata;
        ws_q <= wstrb;
      end
    end
  end

  assign w_addr   = (wr_state == WR_AW) ? aw_q : awaddr;
  assign w_data   = (wr_state == WR_W)  ? wd_q : wdata;
  assign w_strb   = (wr_state == WR_W)  ? ws_q : wstrb;
  assign w_idx    = 32'(w_addr[ADDR_WIDTH-1:2]);
  assign w_sel    = {w_idx[1:0], 5'b0};
  assign ctrl_new = merge_strb(ctrl_q, w_data, w_strb);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bresp      <= '0;
      ctrl_q     <= '0;
      key_q      <= '0;
      nonce_q    <= '0;
      ad_q       <= '0;
      din_q      <= '0;
      dout_q     <= '0;
      tag_q      <= '0;
      end_aead   <= 1'b0;
      dout_ready <= 1'b0;
      ad_valid_q <= 1'b0;
      db_valid_q <= 1'b0;
    end else begin
      if (commit) begin
        bresp <= idx_mapped(w_idx) ? 2'b00 : RESP_SLVERR;
        if (w_idx == 32'd0) begin
          ctrl_q <= ctrl_new;
        end else if (w_idx >= 32'd4 && w_idx <= 32'd19) begin
          case (w_idx[4:2])
            3'd1:    key_q[w_sel +: 32]   <= merge_strb(key_q[w_sel +: 32], w_data, w_strb);
            3'd2:    nonce_q[w_sel +: 32] <= merge_strb(nonce_q[w_sel +: 32], w_data, w_strb);
            3'd3:    ad_q[w_sel +: 32]    <= merge_strb(ad_q[w_sel +: 32], w_data, w_strb);
            default: din_q[w_sel +: 32]   <= merge_strb(din_q[w_sel +: 32], w_data, w_strb);
          endcase
        end
      end

      if (dout_valid) dout_q <= dout;
      if (tag_valid)  tag_q  <= tag;

      // Sticky sets take priority over same-cycle clears.
      if (tag_valid)
        end_aead <= 1'b1;
      else if (commit && w_idx == 32'd0 && !ctrl_q[0] && ctrl_new[0])
        end_aead <= 1'b0;

      if (dout_valid)
        dout_ready <= 1'b1;
      else if (commit && w_idx == 32'd19)
        dout_ready <= 1'b0;

      if (commit && w_idx == 32'd15) ad_valid_q <= 1'b1;
      else if (ad_ready)             ad_valid_q <= 1'b0;

      if (commit && w_idx == 32'd19) db_valid_q <= 1'b1;
      else if (db_ready)             db_valid_q <= 1'b0;
    end
  end

  assign r_idx = 32'(araddr[ADDR_WIDTH-1:2]);
  assign r_sel = {r_idx[1:0], 5'b0};

  always_comb begin
    rd_word = '0;
    rd_ok   = idx_mapped(r_idx);
    if (r_idx == 32'd0) begin
      rd_word = ctrl_q;
    end else if (r_idx == 32'd1) begin
      rd_word = {29'b0, dout_ready, end_aead, core_ready};
    end else if (rd_ok) begin
      case (r_idx[4:2])
        3'd1:    rd_word = key_q[r_sel +: 32];
        3'd2:    rd_word = nonce_q[r_sel +: 32];
        3'd3:    rd_word = ad_q[r_sel +: 32];
        3'd4:    rd_word = din_q[r_sel +: 32];
        3'd5:    rd_word = dout_q[r_sel +: 32];
        3'd6:    rd_word = tag_q[r_sel +: 32];
        default: rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdata <= '0;
      rresp <= '0;
    end else if (rd_load) begin
      rdata <= rd_word;
      rresp <= rd_ok ? 2'b00 : RESP_SLVERR;
    end
  end

  assign key      = key_q;
  assign nonce    = nonce_q;
  assign start    = ctrl_q[0];
  assign op_mode  = ctrl_q[1];
  assign ad_data  = ad_q;
  assign ad_valid = ad_valid_q;
  assign db_data  = din_q;
  assign db_valid = db_valid_q;

endmodule
